// File: rtl/tick_gen_if.sv
// tick_gen_if: event line in, debounced pulse/level out.
// master drives io_in; slave (tick_gen) drives io_enable/io_pressed.
interface tick_gen_if;
  logic io_in;
  logic io_enable;
  logic io_pressed;

  modport master (
    output io_in,
    input  io_enable,
    input  io_pressed
  );

  modport slave (
    input  io_in,
    output io_enable,
    output io_pressed
  );
endinterface

// File: rtl/tick_gen.sv
// tick_gen: 2-flop sync + debounce FSM; one io_enable pulse per press.
// Ports: clock, reset (sync, active-high), bus (io_in / io_enable /
// io_pressed). Define TICK_GEN_AUTOREPEAT_EN for hold-to-repeat pulses.
module tick_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 250
) (
  input  logic        clock,
  input  logic        reset,
  tick_gen_if.slave   bus
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ARMING    = 2'd1;
  localparam logic [1:0] PRESSED   = 2'd2;
  localparam logic [1:0] RELEASING = 2'd3;

  // $clog2(1) is 0, so keep every counter at least one bit wide.
  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 ||
      REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("tick_gen: parameters must be >= 1");
  end

  logic          s1;
  logic          s2;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          enable_q;
  logic          pressed_q;

`ifdef TICK_GEN_AUTOREPEAT_EN
  localparam int RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rcnt;
  // Set after the first repeat: later repeats use the period.
  logic          rpt;
  logic          rep_hit;

  assign rep_hit = rpt ? (rcnt == RP_LAST) : (rcnt == RD_LAST);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      enable_q  <= 1'b0;
      pressed_q <= 1'b0;
`ifdef TICK_GEN_AUTOREPEAT_EN
      rcnt      <= '0;
      rpt       <= 1'b0;
`endif
    end else begin
      s1       <= bus.io_in;
      s2       <= s1;
      enable_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (s2) begin
            state <= ARMING;
            cnt   <= '0;
          end
        end
        ARMING: begin
          if (!s2) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state     <= PRESSED;
            enable_q  <= 1'b1;
            pressed_q <= 1'b1;
`ifdef TICK_GEN_AUTOREPEAT_EN
            rcnt      <= '0;
            rpt       <= 1'b0;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (!s2) begin
            state <= RELEASING;
            cnt   <= '0;
          end
`ifdef TICK_GEN_AUTOREPEAT_EN
          // Only repeat while the line is still seen held.
          if (s2 && rep_hit) begin
            enable_q <= 1'b1;
            rcnt     <= '0;
            rpt      <= 1'b1;
          end else begin
            rcnt <= rcnt + RW'(1);
          end
`endif
        end
        RELEASING: begin
          if (s2) begin
            state <= PRESSED;
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE;
            pressed_q <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.io_enable  = enable_q;
  assign bus.io_pressed = pressed_q;

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: directed press/bounce/release/reset vectors for tick_gen.
// Per-edge outputs are packed into masks and compared to hand values.
module tb_tick_gen;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  logic [3:0] evt_cnt;

  tick_gen_if bus  ();
  tick_gen_if bus1 ();

  tick_gen #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  tick_gen #(
    .DEBOUNCE_CYCLES (1)
  ) u_dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bit e of in_pat/rst_pat is held before edge e; bit e of the
  // outputs is sampled 1ns after edge e.
  task automatic run(input int n,
                     input logic [63:0] in_pat,
                     input logic [63:0] rst_pat,
                     output logic [63:0] en,
                     output logic [63:0] pr,
                     output logic [63:0] en1,
                     output logic [63:0] pr1);
    en  = '0;
    pr  = '0;
    en1 = '0;
    pr1 = '0;
    for (int e = 0; e < n; e++) begin
      bus.io_in  = in_pat[e];
      bus1.io_in = in_pat[e];
      reset      = rst_pat[e];
      @(posedge clock);
      #1;
      en[e]  = bus.io_enable;
      pr[e]  = bus.io_pressed;
      en1[e] = bus1.io_enable;
      pr1[e] = bus1.io_pressed;
      if (bus.io_enable) evt_cnt = evt_cnt + 4'd1;
    end
    reset = 1'b0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    bus.io_in  = 1'b0;
    bus1.io_in = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  logic [63:0] en, pr, en1, pr1, exp_rep;

  initial begin
    checks  = 0;
    errors  = 0;
    evt_cnt = 4'd0;
    reset   = 1'b1;
    bus.io_in  = 1'b0;
    bus1.io_in = 1'b0;

    do_reset();
    check("rst_en",  64'(bus.io_enable),   64'd0);
    check("rst_pr",  64'(bus.io_pressed),  64'd0);
    check("rst_en1", 64'(bus1.io_enable),  64'd0);
    check("rst_pr1", 64'(bus1.io_pressed), 64'd0);

    // Clean press: pulse after edge 6 (D=4), after edge 3 (D=1).
    run(7, 64'h7F, 64'h0, en, pr, en1, pr1);
    check("press_en",  en,  64'h40);
    check("press_pr",  pr,  64'h40);
    check("d1_en",     en1, 64'h08);
    check("d1_pr",     pr1, 64'h78);

    // Release bounce of 2 low cycles: stays pressed, no pulse.
    run(8, 64'hFC, 64'h0, en, pr, en1, pr1);
    check("bounce_en", en, 64'h0);
    check("bounce_pr", pr, 64'hFF);

    // Full release: pressed drops after the 7th edge.
    run(10, 64'h0, 64'h0, en, pr, en1, pr1);
    check("rel_en", en, 64'h0);
    check("rel_pr", pr, 64'h3F);

    // Press glitch of 3 cycles: nothing.
    run(12, 64'h7, 64'h0, en, pr, en1, pr1);
    check("glitch_en", en, 64'h0);
    check("glitch_pr", pr, 64'h0);

    // Hold 30 cycles: auto-repeat at 16, 21, 26, 31 when enabled.
    do_reset();
`ifdef TICK_GEN_AUTOREPEAT_EN
    exp_rep = 64'h84210040;
`else
    exp_rep = 64'h40;
`endif
    run(40, 64'h3FFF_FFFF, 64'h0, en, pr, en1, pr1);
    check("hold_en", en, exp_rep);
    check("hold_pr", pr, 64'hF_FFFF_FFC0);

    // Reset high at edges 4 and 5 mid-ARMING: pulse after edge 12.
    run(16, 64'hFFFF, 64'h30, en, pr, en1, pr1);
    check("rstarm_en", en, 64'h1000);
    check("rstarm_pr", pr, 64'hF000);

    run(12, 64'h0, 64'h0, en, pr, en1, pr1);
    check("rel2_en", en, 64'h0);
    check("rel2_pr", pr, 64'h3F);

    // Two presses separated by 8 low cycles.
    evt_cnt = 4'd0;
    run(40, 64'h00FF_00FF, 64'h0, en, pr, en1, pr1);
    check("b2b_en",  en, 64'h40_0040);
    check("b2b_pr",  pr, 64'h3FC0_3FC0);
    check("b2b_cnt", 64'(evt_cnt), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_gen.md
# tick_gen

Input-conditioning stage that sits directly upstream of the 4-bit event counter and drives its `io_enable` input. It synchronises a raw asynchronous push-button/event line and debounces it. Each accepted press becomes exactly one single-cycle enable pulse, so the counter advances once per physical event. An optional auto-repeat mode emits further pulses while the input is held.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples required to accept a press or release; legal range ≥1.
- `REPEAT_DELAY`, default 1000: PRESSED-state cycles from the initial pulse to the first repeat pulse; legal range ≥1; auto-repeat only.
- `REPEAT_PERIOD`, default 250: PRESSED-state cycles between subsequent repeat pulses; legal range ≥1; auto-repeat only.
- `clock`, input, 1: rising-edge clock.
- `reset`, input, 1: reset, synchronous, active-high; clock clock.
- `io_in`, input, 1: raw asynchronous event line, active-high.
- `io_enable`, output, 1: registered single-cycle pulse; connects to the counter's `io_enable`.
- `io_pressed`, output, 1: registered debounced level of `io_in`.

## Operation
- Synchroniser: two flops, `s1 <= io_in`, `s2 <= s1`, both reset to 0. The FSM observes only `s2`.
- Debounce counter: `cnt`, width $clog2(DEBOUNCE_CYCLES). The FSM has four states, with IDLE as the reset state.
  - IDLE: if `s2`=1, go to ARMING with `cnt`=0.
  - ARMING:
    - If `s2`=0, return to IDLE.
    - Else if `cnt`==DEBOUNCE_CYCLES-1, go to PRESSED and pulse `io_enable`.
    - Else increment `cnt`.
  - PRESSED: if `s2`=0, go to RELEASING with `cnt`=0.
  - RELEASING:
    - If `s2`=1, return to PRESSED with no pulse.
    - Else if `cnt`==DEBOUNCE_CYCLES-1, go to IDLE.
    - Else increment `cnt`.
- `io_pressed`=1 exactly while the state is PRESSED or RELEASING.
- `io_enable` is high for exactly the first cycle after the ARMING→PRESSED transition. It is never high for two consecutive cycles from the debounce path.
- A bounce shorter than DEBOUNCE_CYCLES in either direction produces no pulse and no level change.
- Repeat counter `rcnt`: width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)). It is zeroed on ARMING→PRESSED, advances only in PRESSED cycles, and holds its value in RELEASING.
- Reset mid-operation: the state returns to IDLE and all flops clear. `io_enable`=0 and `io_pressed`=0 in the cycle after the reset edge. If `io_in` is held high through reset, a full debounce is required after reset deasserts.

## Timing
- Reset values: `io_enable`=0, `io_pressed`=0, state=IDLE, `s1`=`s2`=0, `cnt`=`rcnt`=0.
- Press latency: with `io_in` steady high from before edge k, the synchroniser delivers `s2`=1 after edge k+1.
  - Edge k+2 enters ARMING.
  - Edge k+2+DEBOUNCE_CYCLES enters PRESSED.
  - `io_enable` and `io_pressed` are both high in the cycle following that edge.
- Release latency: `io_pressed` falls DEBOUNCE_CYCLES+3 edges after `io_in` falls and stays low.
- DEBOUNCE_CYCLES=1: ARMING lasts exactly one cycle.

## Configuration
- Macro: `TICK_GEN_AUTOREPEAT_EN`.
- Defined: auto-repeat is enabled.
  - While in PRESSED, `io_enable` pulses when `rcnt` reaches REPEAT_DELAY-1 (first repeat).
  - `rcnt` then reloads to 0 and pulses every REPEAT_PERIOD PRESSED cycles.
  - A repeat pulse and the initial pulse never coincide.
- Undefined: `rcnt` and its logic are absent, the REPEAT_* parameters are ignored, and exactly one pulse is emitted per accepted press.

## Test plan
- Clean press, DEBOUNCE_CYCLES=4: `io_in` rises before edge 0 and is held → one `io_enable` pulse in the cycle after edge 6; `io_pressed`=1 from that cycle onward.
- Press glitch, DEBOUNCE_CYCLES=4: `io_in` high for 3 cycles, then low → `io_enable` stays 0 and `io_pressed` stays 0 throughout.
- Release bounce: while pressed, `io_in` low for 2 cycles, then high → `io_pressed` stays 1 and no extra pulse is emitted.
- Full release: `io_pressed` falls 7 edges after `io_in` falls.
- Auto-repeat (macro defined), DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, hold for 30 cycles → pulses after edges 6, 16, 21, 26, 31 only. With the macro undefined, the same stimulus gives a pulse after edge 6 only.
- Reset mid-ARMING: assert `reset` at edge 4 with `io_in` held high → `io_enable`=0 and `io_pressed`=0 after edge 4. After deassert at edge 5, the first pulse appears after edge 12.
- Back-to-back presses separated by 8 low cycles, DEBOUNCE_CYCLES=4 → exactly two pulses, and the downstream counter advances 0→2.
